// File: rtl/bip_control.sv
// Multi-cycle control unit for the BIP I accumulator processor.
// Owns PC, IR and the retired-instruction counter. Each instruction takes a
// FETCH cycle followed by an EXEC cycle, and the datapath strobes are decoded
// from the IR opcode during EXEC.
module bip_control #(
  parameter int PC_WIDTH    = 11,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [15:0]            instr,
  output logic [PC_WIDTH-1:0]    prog_addr,
  output logic [PC_WIDTH-1:0]    data_addr,
  output logic [15:0]            immediate,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   op,
  output logic                   wr_acc,
  output logic                   wr_ram,
  output logic                   rd_ram,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  state_t                 state;
  state_t                 next_state;
  logic [PC_WIDTH-1:0]    pc;
  logic [15:0]            ir;
  logic [4:0]             opcode;

  assign opcode    = ir[15:11];
  assign prog_addr = pc;
  assign data_addr = ir[PC_WIDTH-1:0];
  assign immediate = {{5{ir[10]}}, ir[10:0]};
  assign halted    = (state == HALT);

  // State register; reset drops straight to IDLE so every strobe falls with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // IR capture at the end of FETCH; PC advance and saturating retire count at the end of a non-HLT EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        FETCH: ir <= instr;
        EXEC: begin
          if (opcode != OP_HLT) begin
            pc <= pc + PC_WIDTH'(1);
            if (instr_count != {COUNT_WIDTH{1'b1}}) begin
              instr_count <= instr_count + COUNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state selection and opcode decode into datapath strobes (strobes live only in EXEC).
  always_comb begin
    next_state = state;
    sel_a      = SEL_A_RAM;
    sel_b      = 1'b0;
    op         = 1'b0;
    wr_acc     = 1'b0;
    wr_ram     = 1'b0;
    rd_ram     = 1'b0;
    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        next_state = EXEC;
      end
      EXEC: begin
        if (opcode == OP_HLT) next_state = HALT;
        else if (run)         next_state = FETCH;
        else                  next_state = IDLE;
        case (opcode)
          OP_STO: wr_ram = 1'b1;
          OP_LD: begin
            rd_ram = 1'b1;
            sel_a  = SEL_A_RAM;
            wr_acc = 1'b1;
          end
          OP_LDI: begin
            sel_a  = SEL_A_IMM;
            wr_acc = 1'b1;
          end
          OP_ADD: begin
            rd_ram = 1'b1;
            sel_a  = SEL_A_ALU;
            wr_acc = 1'b1;
          end
          OP_ADDI: begin
            sel_b  = 1'b1;
            sel_a  = SEL_A_ALU;
            wr_acc = 1'b1;
          end
          OP_SUB: begin
            rd_ram = 1'b1;
            op     = 1'b1;
            sel_a  = SEL_A_ALU;
            wr_acc = 1'b1;
          end
          OP_SUBI: begin
            sel_b  = 1'b1;
            op     = 1'b1;
            sel_a  = SEL_A_ALU;
            wr_acc = 1'b1;
          end
          default: ;
        endcase
      end
      HALT: begin
        next_state = HALT;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: opcode decode table, hand-written
// multi-cycle sequences and randomized programs against a behavioural model.
module tb_bip_control;

  localparam int PW   = 11;
  // Narrow retire counter so saturation is reachable in a short run.
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PSZ  = 1 << PW;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_HALT  = 3;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } strobes_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    strobes_t    exp_s;
    logic [15:0] exp_imm;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [15:0]   instr;
  logic [PW-1:0] prog_addr;
  logic [PW-1:0] data_addr;
  logic [15:0]   immediate;
  logic [1:0]    sel_a;
  logic          sel_b;
  logic          op;
  logic          wr_acc;
  logic          wr_ram;
  logic          rd_ram;
  logic          halted;
  logic [CW-1:0] instr_count;

  logic [15:0] prog [0:PSZ-1];

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase of the current instruction plus architectural registers.
  int          m_mode;
  int          m_pc;
  int          m_count;
  logic [15:0] m_ir;

  assign instr = prog[prog_addr];

  always #5 clk = ~clk;

  bip_control #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
    .prog_addr(prog_addr), .data_addr(data_addr), .immediate(immediate),
    .sel_a(sel_a), .sel_b(sel_b), .op(op), .wr_acc(wr_acc), .wr_ram(wr_ram),
    .rd_ram(rd_ram), .halted(halted), .instr_count(instr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic strobes_t dut_strobes();
    strobes_t s;
    s.sel_a  = sel_a;
    s.sel_b  = sel_b;
    s.op     = op;
    s.wr_acc = wr_acc;
    s.wr_ram = wr_ram;
    s.rd_ram = rd_ram;
    return s;
  endfunction

  // Strobes the instruction set asks for, given the instruction phase.
  function automatic strobes_t model_strobes(input int mode, input logic [4:0] opc);
    strobes_t s = '0;
    if (mode == M_EXEC) begin
      case (opc)
        5'd1: s.wr_ram = 1'b1;
        5'd2: begin s.rd_ram = 1'b1; s.wr_acc = 1'b1; end
        5'd3: begin s.sel_a = 2'b01; s.wr_acc = 1'b1; end
        5'd4, 5'd6: begin
          s.rd_ram = 1'b1; s.sel_a = 2'b10; s.wr_acc = 1'b1; s.op = (opc == 5'd6);
        end
        5'd5, 5'd7: begin
          s.sel_b = 1'b1; s.sel_a = 2'b10; s.wr_acc = 1'b1; s.op = (opc == 5'd7);
        end
        default: ;
      endcase
    end
    return s;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = 0;
    m_count = 0;
    m_ir    = '0;
  endtask

  task automatic model_advance(input logic run_now);
    case (m_mode)
      M_IDLE:  if (run_now) m_mode = M_FETCH;
      M_FETCH: begin m_ir = prog[m_pc]; m_mode = M_EXEC; end
      M_EXEC: begin
        if (m_ir[15:11] == 5'd0) begin
          m_mode = M_HALT;
        end else begin
          m_pc    = (m_pc + 1) % PSZ;
          m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
          m_mode  = run_now ? M_FETCH : M_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    int imm;
    imm = int'(m_ir[10:0]);
    if (imm >= 1024) imm = imm - 2048;
    check("prog_addr", 32'(prog_addr), 32'(m_pc));
    check("data_addr", 32'(data_addr), 32'(m_ir[10:0]));
    check("immediate", 32'(immediate), 32'(imm[15:0]));
    check("strobes", 32'(dut_strobes()), 32'(model_strobes(m_mode, m_ir[15:11])));
    check("halted", 32'(halted), 32'(m_mode == M_HALT));
    check("instr_count", 32'(instr_count), 32'(m_count));
  endtask

  // One clock: compare settled outputs, then let the model follow the rising edge.
  task automatic cycle();
    logic run_now;
    compare_model();
    run_now = run;
    @(posedge clk);
    model_advance(run_now);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_strobes", 32'(dut_strobes()), 32'h0);
    check("rst_prog_addr", 32'(prog_addr), 32'h0);
    check("rst_data_addr", 32'(data_addr), 32'h0);
    check("rst_immediate", 32'(immediate), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic fill_nop();
    for (int a = 0; a < PSZ; a++) prog[a] = 16'h5000;
  endtask

  initial begin
    vec_t vecs[10];
    int acc_mask;
    int ram_mask;
    int halt_mask;
    int guard;

    vecs[0] = '{"HLT",   16'h0000, strobes_t'(7'b00_0_0_0_0_0), 16'h0000};
    vecs[1] = '{"STO",   16'h0810, strobes_t'(7'b00_0_0_0_1_0), 16'h0010};
    vecs[2] = '{"LD",    16'h1005, strobes_t'(7'b00_0_0_1_0_1), 16'h0005};
    vecs[3] = '{"LDI",   16'h1FFF, strobes_t'(7'b01_0_0_1_0_0), 16'hFFFF};
    vecs[4] = '{"ADD",   16'h2003, strobes_t'(7'b10_0_0_1_0_1), 16'h0003};
    vecs[5] = '{"ADDI",  16'h2C00, strobes_t'(7'b10_1_0_1_0_0), 16'hFC00};
    vecs[6] = '{"SUB",   16'h3002, strobes_t'(7'b10_0_1_1_0_1), 16'h0002};
    vecs[7] = '{"SUBI",  16'h3801, strobes_t'(7'b10_1_1_1_0_0), 16'h0001};
    vecs[8] = '{"NOP10", 16'h5000, strobes_t'(7'b00_0_0_0_0_0), 16'h0000};
    vecs[9] = '{"NOP31", 16'hF8FF, strobes_t'(7'b00_0_0_0_0_0), 16'h00FF};

    fill_nop();
    @(posedge clk);
    #1;

    // Decode table: each instruction alone at address 0, checked in its EXEC cycle.
    for (int i = 0; i < 10; i++) begin
      run = 1'b0;
      do_reset();
      prog[0] = vecs[i].instr;
      run = 1'b1;
      cycle();
      cycle();
      check({"tbl_strobes_", vecs[i].name}, 32'(dut_strobes()), 32'(vecs[i].exp_s));
      check({"tbl_imm_", vecs[i].name}, 32'(immediate), 32'(vecs[i].exp_imm));
      run = 1'b0;
      cycle();
      cycle();
    end

    // Short program: LDI 5; ADDI 3; STO 0x010; HLT.
    fill_nop();
    prog[0] = 16'h1805;
    prog[1] = 16'h2803;
    prog[2] = 16'h0810;
    prog[3] = 16'h0000;
    run = 1'b0;
    do_reset();
    run = 1'b1;
    acc_mask = 0;
    ram_mask = 0;
    halt_mask = 0;
    for (int k = 0; k < 12; k++) begin
      if (wr_acc) acc_mask |= (1 << k);
      if (wr_ram) begin
        ram_mask |= (1 << k);
        check("prog_sto_addr", 32'(data_addr), 32'h010);
      end
      if (halted) halt_mask |= (1 << k);
      if (k == 10) run = 1'b0;
      cycle();
    end
    check("prog_wr_acc_cycles", 32'(acc_mask), 32'h014);
    check("prog_wr_ram_cycles", 32'(ram_mask), 32'h040);
    check("prog_halted_cycles", 32'(halt_mask), 32'hE00);
    check("prog_count", 32'(instr_count), 32'd3);
    check("prog_pc", 32'(prog_addr), 32'd3);

    // Pause during the EXEC of the second instruction, then resume.
    fill_nop();
    run = 1'b0;
    do_reset();
    run = 1'b1;
    guard = 0;
    while (!(m_mode == M_EXEC && m_pc == 1) && guard < 20) begin
      cycle();
      guard++;
    end
    check("pause_reach_exec", 32'(guard < 20), 32'd1);
    run = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    check("pause_pc", 32'(prog_addr), 32'd2);
    check("pause_count", 32'(instr_count), 32'd2);
    check("pause_idle_strobes", 32'(dut_strobes()), 32'h0);
    run = 1'b1;
    cycle();
    check("resume_fetch_addr", 32'(prog_addr), 32'd2);
    for (int k = 0; k < 4; k++) cycle();

    // Long NOP loop: PC wraps past the top address and the counter saturates.
    fill_nop();
    run = 1'b0;
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 1 + 2 * PSZ; k++) begin
      cycle();
      if (k == 1 + 2 * (CMAX - 1)) check("sat_before", 32'(instr_count), 32'(CMAX - 1));
      if (k == 1 + 2 * (CMAX + 1)) check("sat_hold", 32'(instr_count), 32'(CMAX));
      if (k == 1 + 2 * (PSZ - 1)) check("wrap_top_pc", 32'(prog_addr), 32'(PSZ - 1));
    end
    check("wrap_pc_zero", 32'(prog_addr), 32'd0);
    check("sat_final", 32'(instr_count), 32'(CMAX));

    // Reset asserted in the middle of a STO EXEC.
    fill_nop();
    prog[0] = 16'h0810;
    run = 1'b0;
    do_reset();
    run = 1'b1;
    cycle();
    cycle();
    check("sto_wr_ram_before", 32'(wr_ram), 32'd1);
    #2;
    run = 1'b0;
    do_reset();
    check("sto_abort_wr_ram", 32'(wr_ram), 32'd0);
    for (int k = 0; k < 4; k++) cycle();
    check("sto_abort_idle_pc", 32'(prog_addr), 32'd0);

    // Randomized programs with random Run toggling.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < PSZ; a++) begin
        logic [4:0] opc;
        opc = ($urandom_range(0, 59) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        prog[a] = {opc, 11'($urandom)};
      end
      run = 1'b0;
      do_reset();
      for (int k = 0; k < 400; k++) begin
        run = ($urandom_range(0, 7) != 0);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
